// File: rtl/issue_buffer_pkg.sv
// issue_buffer_pkg: shared FU counts, branch-mask and packet types for the issue stage.
package issue_buffer_pkg;
  localparam int NUM_FU_ALU = 1;
  localparam int NUM_FU_MULT = 1;
  localparam int NUM_FU_LD = 1;
  localparam int NUM_FU_STORE = 1;
  localparam int NUM_FU_BR = 1;
  localparam int NUM_FUS = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LD + NUM_FU_STORE + NUM_FU_BR;
  localparam int BRANCH_PRED_SZ = 4;
  localparam int PHYS_REG_IDX_W = 6;
  localparam int DATA_W = 32;
  typedef logic [BRANCH_PRED_SZ-1:0] br_mask_t;
  typedef logic [PHYS_REG_IDX_W-1:0] phys_reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef struct packed {
    logic valid;
    logic [31:0] inst;
    phys_reg_idx_t dest_reg_idx;
  } decoded_t;
  typedef struct packed {
    phys_reg_idx_t reg_idx;
    logic ready;
  } phys_tag_t;
  typedef struct packed {
    decoded_t decoded_vals;
    phys_tag_t t1;
    phys_tag_t t2;
    br_mask_t b_mask;
  } rs_packet_t;
  typedef struct packed {
    rs_packet_t decoded_vals;
    data_t rs1_value;
    data_t rs2_value;
  } issue_packet_t;
  function automatic logic mask_hit(input br_mask_t m, input br_mask_t sel);
    return |(m & sel);
  endfunction
endpackage

// File: rtl/issue_chan_fifo.sv
// issue_chan_fifo: one FU channel's in-order queue with push, pop, squash compaction and resolve clear.
module issue_chan_fifo
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  rs_packet_t    push_pkt,
  input  logic          push_valid,
  input  logic          pop,
  input  logic          br_squash,
  input  br_mask_t      squash_mask,
  input  logic          br_resolve,
  input  br_mask_t      resolve_mask,
  output rs_packet_t    head,
  output logic          head_valid,
  output logic          in_ready,
  output logic [CW-1:0] occupancy
);
  rs_packet_t ent_q [DEPTH];
  rs_packet_t ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d, rank;
  logic in_ready_q, in_ready_d;
  logic push_ok;
  br_mask_t clr_mask;
  assign head = ent_q[0];
  assign head_valid = (count_q != '0) & ~(br_squash & mask_hit(ent_q[0].b_mask, squash_mask));
  assign in_ready = in_ready_q;
  assign occupancy = count_q;
  // Survivors are packed toward slot 0 in order; slots past the count stay zero so an empty head reads 0.
  always_comb begin
    clr_mask = br_resolve ? ~resolve_mask : '1;
    push_ok = push_valid & in_ready_q & push_pkt.decoded_vals.valid & ~(br_squash & mask_hit(push_pkt.b_mask, squash_mask));
    rank = '0;
    for (int d = 0; d < DEPTH; d++) ent_d[d] = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count_q) && !(k == 0 && pop && head_valid) && !(br_squash && mask_hit(ent_q[k].b_mask, squash_mask))) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (d == int'(rank)) begin
            ent_d[d] = ent_q[k];
            ent_d[d].b_mask = ent_q[k].b_mask & clr_mask;
          end
        end
        rank = rank + CW'(1);
      end
    end
    for (int d = 0; d < DEPTH; d++) begin
      if (push_ok && d == int'(rank)) begin
        ent_d[d] = push_pkt;
        ent_d[d].b_mask = push_pkt.b_mask & clr_mask;
      end
    end
    count_d = rank + CW'(push_ok);
    in_ready_d = int'(count_d) < DEPTH;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_q <= '{default: '0};
      count_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      count_q <= count_d;
      in_ready_q <= in_ready_d;
    end
  end
endmodule

// File: rtl/issue_buffer.sv
// issue_buffer: per-FU issue queues between RS select and the functional units,
// muxing each head's register indices out and regfile data back into the issue packet.
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int NUM_CH = NUM_FUS,
  parameter int DEPTH = 2,
  parameter logic [NUM_CH-1:0] CH_STALLABLE = {{NUM_FU_BR{1'b0}}, {(NUM_CH - NUM_FU_BR){1'b1}}},
  parameter int BR_W = BRANCH_PRED_SZ
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  rs_packet_t    [NUM_CH-1:0]                in_pkt,
  input  logic          [NUM_CH-1:0]                in_valid,
  output logic          [NUM_CH-1:0]                in_ready,
  output phys_reg_idx_t [NUM_CH-1:0]                reg_idx_1,
  output phys_reg_idx_t [NUM_CH-1:0]                reg_idx_2,
  input  data_t         [NUM_CH-1:0]                reg_data_1,
  input  data_t         [NUM_CH-1:0]                reg_data_2,
  output issue_packet_t [NUM_CH-1:0]                out_pkt,
  output logic          [NUM_CH-1:0]                out_valid,
  input  logic          [NUM_CH-1:0]                fu_ready,
  input  logic                                      br_squash,
  input  logic          [BR_W-1:0]                  br_squash_mask,
  input  logic                                      br_resolve,
  input  logic          [BR_W-1:0]                  br_resolve_mask,
  output logic          [NUM_CH-1:0][$clog2(DEPTH+1)-1:0] occupancy
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rs_packet_t head;
    // Non-stallable FUs (branch) always take the head, so their fu_ready is ignored.
    issue_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_pkt    (in_pkt[i]),
      .push_valid  (in_valid[i]),
      .pop         (out_valid[i] & (fu_ready[i] | ~CH_STALLABLE[i])),
      .br_squash   (br_squash),
      .squash_mask (br_squash_mask),
      .br_resolve  (br_resolve),
      .resolve_mask(br_resolve_mask),
      .head        (head),
      .head_valid  (out_valid[i]),
      .in_ready    (in_ready[i]),
      .occupancy   (occupancy[i])
    );
    assign reg_idx_1[i] = head.t1.reg_idx;
    assign reg_idx_2[i] = head.t2.reg_idx;
    assign out_pkt[i] = '{decoded_vals: head, rs1_value: reg_data_1[i], rs2_value: reg_data_2[i]};
  end
endmodule

// File: tb/tb_issue_buffer.sv
// tb_issue_buffer: directed scenarios then randomized traffic, checked against per-channel queue model.
module tb_issue_buffer;
  import issue_buffer_pkg::*;
  localparam int NCH = NUM_FUS;
  localparam int DEPTH = 3;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BR = NUM_FUS - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  rs_packet_t    [NCH-1:0] in_pkt;
  logic          [NCH-1:0] in_valid, in_ready, out_valid, fu_ready;
  phys_reg_idx_t [NCH-1:0] reg_idx_1, reg_idx_2;
  data_t         [NCH-1:0] reg_data_1, reg_data_2;
  issue_packet_t [NCH-1:0] out_pkt;
  logic br_squash, br_resolve;
  br_mask_t br_squash_mask, br_resolve_mask;
  logic [NCH-1:0][CW-1:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;
  logic rf_mode = 1'b0;
  rs_packet_t mq [NCH][$];
  logic [NCH-1:0] ready_m;

  always #5 clock = ~clock;

  issue_buffer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_pkt         (in_pkt),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .reg_idx_1      (reg_idx_1),
    .reg_idx_2      (reg_idx_2),
    .reg_data_1     (reg_data_1),
    .reg_data_2     (reg_data_2),
    .out_pkt        (out_pkt),
    .out_valid      (out_valid),
    .fu_ready       (fu_ready),
    .br_squash      (br_squash),
    .br_squash_mask (br_squash_mask),
    .br_resolve     (br_resolve),
    .br_resolve_mask(br_resolve_mask),
    .occupancy      (occupancy)
  );

  function automatic data_t rf1(input phys_reg_idx_t x);
    return 32'hA500_0000 | 32'(x);
  endfunction
  function automatic data_t rf2(input phys_reg_idx_t x);
    return 32'h5A00_0000 | (32'(x) << 8);
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      reg_data_1[i] = rf_mode ? rf1(reg_idx_1[i]) : 32'h11;
      reg_data_2[i] = rf_mode ? rf2(reg_idx_2[i]) : 32'h22;
    end
  end

  task automatic chk(input string tag, input int ch, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  function automatic logic hit(input br_mask_t m, input logic en, input br_mask_t s);
    return en && ((m & s) != '0);
  endfunction

  function automatic logic exp_valid(input int ch);
    if (mq[ch].size() == 0) return 1'b0;
    return !hit(mq[ch][0].b_mask, br_squash, br_squash_mask);
  endfunction

  function automatic rs_packet_t mk(input logic [31:0] inst, input phys_reg_idx_t a, input phys_reg_idx_t b, input br_mask_t m);
    rs_packet_t p;
    p = '0;
    p.decoded_vals.valid = 1'b1;
    p.decoded_vals.inst = inst;
    p.decoded_vals.dest_reg_idx = inst[5:0];
    p.t1.reg_idx = a;
    p.t2.reg_idx = b;
    p.b_mask = m;
    return p;
  endfunction

  task automatic check_all();
    rs_packet_t h;
    issue_packet_t e;
    for (int ch = 0; ch < NCH; ch++) begin
      h = '0;
      if (mq[ch].size() != 0) h = mq[ch][0];
      chk("in_ready", ch, 128'(in_ready[ch]), 128'(ready_m[ch]));
      chk("occupancy", ch, 128'(occupancy[ch]), 128'(mq[ch].size()));
      chk("out_valid", ch, 128'(out_valid[ch]), 128'(exp_valid(ch)));
      chk("reg_idx_1", ch, 128'(reg_idx_1[ch]), 128'(h.t1.reg_idx));
      chk("reg_idx_2", ch, 128'(reg_idx_2[ch]), 128'(h.t2.reg_idx));
      if (exp_valid(ch)) begin
        e.decoded_vals = h;
        e.rs1_value = rf_mode ? rf1(h.t1.reg_idx) : 32'h11;
        e.rs2_value = rf_mode ? rf2(h.t2.reg_idx) : 32'h22;
        chk("out_pkt", ch, 128'(out_pkt[ch]), 128'(e));
      end
    end
  endtask

  // Model: each channel is a program-ordered queue; apply pop, squash filter, resolve clear, then push.
  task automatic update();
    rs_packet_t nq [$];
    rs_packet_t p;
    br_mask_t keep;
    keep = br_resolve ? ~br_resolve_mask : '1;
    for (int ch = 0; ch < NCH; ch++) begin
      nq.delete();
      if (exp_valid(ch) && (fu_ready[ch] || ch == BR)) void'(mq[ch].pop_front());
      for (int j = 0; j < mq[ch].size(); j++) begin
        if (!hit(mq[ch][j].b_mask, br_squash, br_squash_mask)) begin
          p = mq[ch][j];
          p.b_mask = p.b_mask & keep;
          nq.push_back(p);
        end
      end
      if (ready_m[ch] && in_valid[ch] && in_pkt[ch].decoded_vals.valid && !hit(in_pkt[ch].b_mask, br_squash, br_squash_mask)) begin
        p = in_pkt[ch];
        p.b_mask = p.b_mask & keep;
        nq.push_back(p);
      end
      mq[ch] = nq;
      ready_m[ch] = nq.size() < DEPTH;
    end
  endtask

  task automatic cycle();
    #2;
    check_all();
    @(posedge clock);
    update();
    @(negedge clock);
  endtask

  task automatic idle();
    in_valid = '0;
    br_squash = 1'b0;
    br_resolve = 1'b0;
    br_squash_mask = '0;
    br_resolve_mask = '0;
  endtask

  initial begin
    int s, r;
    in_pkt = '0;
    fu_ready = '1;
    ready_m = '0;
    idle();
    repeat (2) @(negedge clock);
    #1 check_all();
    @(negedge clock);
    reset = 1'b0;
    cycle();
    cycle();
    chk("in_ready_after_reset", 0, 128'(in_ready), 128'({NCH{1'b1}}));

    in_pkt[0] = mk(32'd1, 6'd5, 6'd7, 4'b0000);
    in_valid[0] = 1'b1;
    cycle();
    idle();
    #1;
    chk("alu_reg_idx_1", 0, 128'(reg_idx_1[0]), 128'(5));
    chk("alu_reg_idx_2", 0, 128'(reg_idx_2[0]), 128'(7));
    chk("alu_out_valid", 0, 128'(out_valid[0]), 128'(1));
    chk("alu_rs1", 0, 128'(out_pkt[0].rs1_value), 128'(32'h11));
    chk("alu_rs2", 0, 128'(out_pkt[0].rs2_value), 128'(32'h22));
    cycle();
    chk("alu_popped", 0, 128'(occupancy[0]), 128'(0));

    fu_ready[1] = 1'b0;
    in_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_pkt[1] = mk(32'(2 + k), 6'(1 + k), 6'(9 + k), 4'b0000);
      cycle();
    end
    idle();
    #1;
    chk("fill_occupancy", 1, 128'(occupancy[1]), 128'(DEPTH));
    chk("fill_in_ready", 1, 128'(in_ready[1]), 128'(0));
    chk("fill_head", 1, 128'(out_pkt[1].decoded_vals.decoded_vals.inst), 128'(2));
    fu_ready[1] = 1'b1;
    cycle();
    chk("drain_head_b", 1, 128'(out_pkt[1].decoded_vals.decoded_vals.inst), 128'(3));
    cycle();
    chk("drain_head_c", 1, 128'(out_pkt[1].decoded_vals.decoded_vals.inst), 128'(4));
    cycle();
    chk("drain_in_ready", 1, 128'(in_ready[1]), 128'(1));

    fu_ready = '0;
    in_pkt[BR] = mk(32'd5, 6'd8, 6'd9, 4'b0100);
    in_valid[BR] = 1'b1;
    cycle();
    idle();
    #1 chk("br_out_valid", BR, 128'(out_valid[BR]), 128'(1));
    cycle();
    chk("br_popped", BR, 128'(occupancy[BR]), 128'(0));

    in_valid[2] = 1'b1;
    in_pkt[2] = mk(32'd6, 6'd11, 6'd12, 4'b0001);
    cycle();
    in_pkt[2] = mk(32'd7, 6'd13, 6'd14, 4'b0010);
    cycle();
    in_pkt[2] = mk(32'd8, 6'd15, 6'd16, 4'b0000);
    cycle();
    idle();
    br_squash = 1'b1;
    br_squash_mask = 4'b0010;
    cycle();
    idle();
    #1;
    chk("squash_occupancy", 2, 128'(occupancy[2]), 128'(2));
    chk("squash_head_a", 2, 128'(out_pkt[2].decoded_vals.decoded_vals.inst), 128'(6));
    in_valid[2] = 1'b1;
    in_pkt[2] = mk(32'd9, 6'd17, 6'd18, 4'b0010);
    br_squash = 1'b1;
    br_squash_mask = 4'b0010;
    cycle();
    idle();
    #1 chk("squash_push_dropped", 2, 128'(occupancy[2]), 128'(2));
    br_resolve = 1'b1;
    br_resolve_mask = 4'b0001;
    cycle();
    idle();
    #1 chk("resolve_clear", 2, 128'(out_pkt[2].decoded_vals.b_mask), 128'(0));
    br_squash = 1'b1;
    br_squash_mask = 4'b0001;
    cycle();
    idle();
    #1 chk("resolved_survives", 2, 128'(occupancy[2]), 128'(2));
    fu_ready[2] = 1'b1;
    cycle();
    fu_ready[2] = 1'b0;
    #1 chk("order_head_c", 2, 128'(out_pkt[2].decoded_vals.decoded_vals.inst), 128'(8));

    reset = 1'b1;
    #1;
    chk("async_out_valid", 0, 128'(out_valid), 128'(0));
    chk("async_occupancy", 2, 128'(occupancy[2]), 128'(0));
    chk("async_in_ready", 0, 128'(in_ready), 128'(0));
    for (int ch = 0; ch < NCH; ch++) mq[ch].delete();
    ready_m = '0;
    @(negedge clock);
    reset = 1'b0;
    cycle();

    rf_mode = 1'b1;
    repeat (600) begin
      for (int ch = 0; ch < NCH; ch++) begin
        in_valid[ch] = 1'($urandom);
        in_pkt[ch] = mk($urandom, 6'($urandom), 6'($urandom), 4'($urandom & $urandom));
        in_pkt[ch].decoded_vals.valid = ($urandom_range(0, 7) != 0);
      end
      fu_ready = NCH'($urandom);
      s = $urandom_range(0, 3);
      r = (s + 1 + $urandom_range(0, 2)) % 4;
      br_squash = ($urandom_range(0, 5) == 0);
      br_squash_mask = 4'(1 << s);
      br_resolve = ($urandom_range(0, 3) == 0);
      br_resolve_mask = 4'(1 << r);
      cycle();
    end
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
